map_port_arbiter: RTL and testbench
===================================

// Module: map_port_arbiter
// PURPOSE
// - Shares the single read/write port B of the 32x36 tile map BRAM among NUM_REQ requesters:
//   pacman movement, candy/cookie eating, and the ghost movers.
// - Removes the per-mover map copies.
// - Serialises read, write and atomic-swap requests with round-robin fairness.
// - Swap makes eat-and-clear atomic against concurrent readers.
// - Sits between the movement/cookie blocks and the port B pins of the map memory.
// PARAMETERS
// - NUM_REQ  5     number of requesters; index 0 is pacman.
// - ADDR_W   11    tile address width; 32*36 = 1152 entries.
// - DATA_W   4     tile code width.
// PORTS
// - vga_pix_clk  in   1                  sole clock, rising edge.
// - rst_n        in   1                  asynchronous, active-low reset.
// - req_valid    in   NUM_REQ            request pending; held until req_ready.
// - req_op       in   NUM_REQ x 2        map_arb_pkg::op_e (OP_RD, OP_WR, OP_SWAP).
// - req_addr     in   NUM_REQ x ADDR_W   tile index = x/8 + (y/8)*32.
// - req_wdata    in   NUM_REQ x DATA_W   write/swap data.
// - req_ready    out  NUM_REQ            one-hot accept pulse, combinational.
// - rsp_valid    out  NUM_REQ            one-hot response pulse, registered.
// - rsp_data     out  DATA_W             read data, or old data for swap; 0 for write.
// - bram_en      out  1                  port B enable.
// - bram_we      out  1                  port B write enable.
// - bram_addr    out  ADDR_W             port B address.
// - bram_din     out  DATA_W             port B write data.
// - bram_dout    in   DATA_W             port B read data; 1-cycle latency.
// - addr_err     out  1                  sticky flag: an out-of-range address was accepted.
// BEHAVIOUR
// - Reset values: state IDLE, rr pointer NUM_REQ-1, rsp_valid 0, rsp_data 0, addr_err 0.
// - Reset drives all bram_* outputs to 0. req_ready is 0 while rst_n is low.
// - FSM, IDLE state:
//   - Pick winner w among req_valid; assert req_ready[w], same cycle (cycle t).
//   - Drive bram_en=1 and bram_addr=req_addr[w].
//   - bram_we=1, bram_din=wdata only for OP_WR.
//   - Latch w, op, addr and wdata, then go to RESP.
//   - No valid request: stay in IDLE, all bram_* outputs 0.
// - FSM, RESP state (cycle t+1):
//   - bram_dout holds the old tile value.
//   - OP_SWAP: bram_en=1, bram_we=1, bram_addr=latched addr, bram_din=latched wdata.
//   - Register rsp_valid[w]=1 and rsp_data = dout (RD/SWAP) or 0 (WR).
//   - Return to IDLE.
// - Timing: rsp_valid visible at t+2 for one cycle. Peak throughput is 1 op per 2 cycles. No grant is issued in RESP.
// - Arbitration: round robin starting at ptr+1 and wrapping modulo NUM_REQ; ptr <= w on each grant.
// - Write ordering: a write/swap accepted at t is visible to any read granted at t+2 or later. No stale reads.
// - Out-of-range address (addr >= 1152):
//   - Request is still accepted and gets normal ready/rsp timing.
//   - bram_en is held 0 and rsp_data is 0.
//   - addr_err sets and clears only on reset.
// - Valid dropped before ready is a protocol violation; the bench asserts on it.
// - A requester may re-request in the cycle of its own rsp_valid.
// - Reset mid-operation (rst_n low in RESP): the swap write is suppressed immediately, since bram_we is decoded from state. Memory keeps the old value and no rsp is issued.
// - Simultaneous valid from every requester: each is served exactly once per NUM_REQ grants.
// CONFIGURATION
// - MAP_ARB_PACMAN_PRIO_EN defined:
//   - Requester 0 wins whenever it is valid; the rest use round robin among themselves.
//   - ptr updates only on non-0 grants.
// - MAP_ARB_PACMAN_PRIO_EN undefined: pure round robin, requester 0 has no precedence.
// STRUCTURE
// - Package map_arb_pkg: op_e enum, MAP_COLS=32, MAP_ROWS=36, MAP_DEPTH=1152.
// - map_arb_pkg also holds tile code constants: TILE_EMPTY=4'b1000, candy, power cookie.
// - Sub-module map_rr_pick: combinational round-robin picker.
//   - Inputs: req vector, ptr, prio-enable.
//   - Outputs: one-hot grant, winner index, any.
// - The top holds the FSM, latches and the response register.
// TESTING (bench models BRAM with 1-cycle read, preloaded from map.mem)
// 1. req0 OP_RD addr 33 (tile 4'h1) at t -> req_ready[0] at t; rsp_valid[0] at t+2, rsp_data=4'h1.
// 2. All 5 valid OP_RD, held -> grant order 0,1,2,3,4, then back to 0; grants 2 cycles apart; each rsp_valid one-hot.
// 3. req0 OP_SWAP addr 40, wdata 4'h8, old 4'h2 -> rsp_data=4'h2, bram_we in RESP only; a later read of 40 returns 4'h8.
// 4. ptr=4; req0 SWAP(40,8) and req1 RD(40) in the same cycle -> req0 first, then req1 gets rsp_data=4'h8.
// 5. req0 and req1 both held valid:
//    - macro on -> req0 wins every grant.
//    - macro off -> grants alternate 0,1,0,1.
// 6. rst_n low in the RESP cycle of SWAP(50,8), old 4'h1 ->
//    - no write; addr 50 still reads 4'h1;
//    - all outputs 0; FSM in IDLE.
// 7. req2 OP_RD addr 1152 -> bram_en stays 0, rsp_data=0 at t+2, addr_err=1 until reset.

Source files
------------

// File: rtl/map_arb_pkg.sv
// Shared types and constants for the tile-map port B arbiter.
package map_arb_pkg;

  localparam int unsigned MAP_COLS  = 32;
  localparam int unsigned MAP_ROWS  = 36;
  localparam int unsigned MAP_DEPTH = MAP_COLS * MAP_ROWS;

  typedef enum logic [1:0] {
    OP_RD   = 2'd0,
    OP_WR   = 2'd1,
    OP_SWAP = 2'd2
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  localparam logic [3:0] TILE_EMPTY  = 4'b1000;
  localparam logic [3:0] TILE_CANDY  = 4'b0001;
  localparam logic [3:0] TILE_COOKIE = 4'b0010;

  function automatic logic tile_in_map(input int unsigned addr);
    return addr < MAP_DEPTH;
  endfunction

endpackage

// File: rtl/map_rr_pick.sv
// Round-robin picker: search starts at ptr+1 and wraps; with prio_en, bit 0 wins outright.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
module map_rr_pick #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               prio_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin : pick
    int cand;
    logic [IDX_W-1:0] cand_i;
    cand   = 0;
    cand_i = '0;
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    if (prio_en && req[0]) begin
      gnt[0] = 1'b1;
      any    = 1'b1;
    end else begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        cand   = (int'(ptr) + off) % NUM_REQ;
        cand_i = IDX_W'(cand);
        // with priority on, requester 0 is never a round-robin candidate
        if (!any && req[cand_i] && !(prio_en && cand == 0)) begin
          gnt[cand_i] = 1'b1;
          idx         = cand_i;
          any         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/map_port_arbiter.sv
// Shares map BRAM port B among NUM_REQ requesters (RD/WR/atomic SWAP); MAP_ARB_PACMAN_PRIO_EN gives requester 0 precedence.
// Latency: req_ready same cycle as grant, rsp_valid two cycles later; at most one op per two cycles.
// Backpressure: requesters hold req_valid until req_ready; no grant is issued while a response is in flight.
module map_port_arbiter
  import map_arb_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4
) (
  input  logic                            vga_pix_clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][1:0]         req_op,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_W-1:0]               rsp_data,
  output logic                            bram_en,
  output logic                            bram_we,
  output logic [ADDR_W-1:0]               bram_addr,
  output logic [DATA_W-1:0]               bram_din,
  input  logic [DATA_W-1:0]               bram_dout,
  output logic                            addr_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef MAP_ARB_PACMAN_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    w_q;
  op_e                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_map_q;

  logic [NUM_REQ-1:0]  win_gnt;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  op_e                 win_op;
  logic                win_in_map;
  logic                grant;

  map_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .prio_en (PRIO_EN),
    .gnt     (win_gnt),
    .idx     (win_idx),
    .any     (win_any)
  );

  assign win_op     = op_e'(req_op[win_idx]);
  assign win_in_map = tile_in_map(32'(req_addr[win_idx]));

  // bram_* are decoded from state so a reset in RESP kills the swap write at once
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    req_ready = '0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && win_any) begin
          grant     = 1'b1;
          req_ready = win_gnt;
          bram_en   = win_in_map;
          bram_addr = req_addr[win_idx];
          if (win_op == OP_WR) begin
            bram_we  = win_in_map;
            bram_din = req_wdata[win_idx];
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (op_q == OP_SWAP && in_map_q) begin
          bram_en   = 1'b1;
          bram_we   = 1'b1;
          bram_addr = addr_q;
          bram_din  = wdata_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      w_q       <= '0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      in_map_q  <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      addr_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= '0;
      if (grant) begin
        w_q      <= win_idx;
        op_q     <= win_op;
        addr_q   <= req_addr[win_idx];
        wdata_q  <= req_wdata[win_idx];
        in_map_q <= win_in_map;
        if (!win_in_map) addr_err <= 1'b1;
        if (!(PRIO_EN && win_idx == '0)) ptr_q <= win_idx;
      end
      if (state_q == ST_RESP) begin
        rsp_valid <= NUM_REQ'(1) << w_q;
        rsp_data  <= (op_q != OP_WR && in_map_q) ? bram_dout : '0;
      end
    end
  end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Bench for map_port_arbiter: 1-cycle BRAM model plus a transaction-level reference of grants and tile contents.
module tb_map_port_arbiter;
  import map_arb_pkg::*;

  localparam int N = 5;
  localparam int DEPTH = 1152;

  logic                  vga_pix_clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N-1:0]          req_valid;
  logic [N-1:0][1:0]     req_op;
  logic [N-1:0][10:0]    req_addr;
  logic [N-1:0][3:0]     req_wdata;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          rsp_valid;
  logic [3:0]            rsp_data;
  logic                  bram_en, bram_we;
  logic [10:0]           bram_addr;
  logic [3:0]            bram_din;
  logic [3:0]            bram_dout = 4'h0;
  logic                  addr_err;

  always #5 vga_pix_clk = ~vga_pix_clk;

  map_port_arbiter #(.NUM_REQ(N), .ADDR_W(11), .DATA_W(4)) dut (
    .vga_pix_clk (vga_pix_clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_dout   (bram_dout),
    .addr_err    (addr_err)
  );

  // tile memory with 1-cycle read; poke port lets the bench preload it
  logic [3:0]  bmem [0:DEPTH-1];
  logic        poke_en = 1'b0;
  logic [10:0] poke_addr = '0;
  logic [3:0]  poke_dat = '0;

  always @(posedge vga_pix_clk) begin
    if (poke_en) bmem[poke_addr] <= poke_dat;
    else if (bram_en && int'(bram_addr) < DEPTH) begin
      if (bram_we) bmem[bram_addr] <= bram_din;
      bram_dout <= bmem[bram_addr];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_proto
    a_hold: assert property (@(posedge vga_pix_clk) disable iff (!rst_n)
                             (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
  end

  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0;
  int         m_last, m_gcyc, m_pw;
  logic [3:0] m_pd;
  logic       m_err;
  logic [3:0] mmem [0:DEPTH-1];
  int         glog[$], gcyc[$];
  logic [3:0] last_rd = 4'h0;
  logic [N-1:0] keep = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] tile_init(input int i);
    case (i)
      33: return 4'h1;
      40: return 4'h2;
      50: return 4'h1;
      default: return 4'((i * 5 + 3) % 16);
    endcase
  endfunction

  // next requester in circular order after the last served one
  function automatic int m_pick(input logic [N-1:0] v);
`ifdef MAP_ARB_PACMAN_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (m_last + off) % N;
`ifdef MAP_ARB_PACMAN_PRIO_EN
      if (c == 0) continue;
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step;
    logic [N-1:0] exp_rdy, exp_rv, acc;
    logic [1:0]   op;
    int           w, a;
    @(negedge vga_pix_clk);
    exp_rdy = '0;
    exp_rv  = '0;
    w       = -1;
    if (cyc >= m_gcyc + 2 && req_valid != '0) begin
      w = m_pick(req_valid);
      if (w >= 0) exp_rdy[w] = 1'b1;
    end
    if (cyc == m_gcyc + 2) exp_rv[m_pw] = 1'b1;
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("addr_err", 32'(addr_err), 32'(m_err));
    if (cyc == m_gcyc + 2) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_pd));
      last_rd = rsp_data;
    end
    if (bram_en) chk("bram_in_map", 32'(int'(bram_addr) < DEPTH), 32'd1);
    if (w >= 0) begin
      op = req_op[w];
      a  = int'(req_addr[w]);
      m_pd = (op == OP_WR || a >= DEPTH) ? 4'h0 : mmem[a];
      if (op != OP_RD && a < DEPTH) mmem[a] = req_wdata[w];
      if (a >= DEPTH) m_err = 1'b1;
      m_gcyc = cyc;
      m_pw   = w;
      glog.push_back(w);
      gcyc.push_back(cyc);
`ifdef MAP_ARB_PACMAN_PRIO_EN
      if (w != 0) m_last = w;
`else
      m_last = w;
`endif
    end
    acc = req_ready;
    cyc++;
    @(posedge vga_pix_clk);
    #1;
    req_valid = req_valid & ~(acc & ~keep);
    poke_en   = 1'b0;
  endtask

  task automatic req(input int i, input logic [1:0] op, input int a, input logic [3:0] d);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_addr[i]  = 11'(a);
    req_wdata[i] = d;
  endtask

  task automatic reset_model;
    m_last = N - 1;
    m_gcyc = -100;
    m_err  = 1'b0;
    keep   = '0;
    glog.delete();
    gcyc.delete();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    chk("rst_bram_addr", 32'(bram_addr), 32'd0);
    repeat (2) @(posedge vga_pix_clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
  endtask

  task automatic drain;
    keep = '0;
    for (int k = 0; k < 40; k++) begin
      if (req_valid == '0 && cyc >= m_gcyc + 3) return;
      step();
    end
    chk("drain_timeout", 32'(req_valid), 32'd0);
  endtask

  initial begin
    req_valid = '0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    reset_model();
    #2 rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      poke_en   = 1'b1;
      poke_addr = 11'(i);
      poke_dat  = tile_init(i);
      mmem[i]   = tile_init(i);
      @(posedge vga_pix_clk);
      #1;
    end
    poke_en = 1'b0;
    do_reset();

    // single read of a candy tile
    req(0, OP_RD, 33, 4'h0);
    last_rd = 4'hf;
    repeat (3) step();
    chk("t1_ngrant", 32'(glog.size()), 32'd1);
    chk("t1_data", 32'(last_rd), 32'h1);
    drain();

    // everyone held valid: rotation and two-cycle spacing
    do_reset();
    keep = '1;
    for (int i = 0; i < N; i++) req(i, OP_RD, 100 + i, 4'h0);
    repeat (12) step();
    keep = '0;
    chk("t2_ngrant", 32'(glog.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < glog.size(); k++) begin
`ifdef MAP_ARB_PACMAN_PRIO_EN
      chk("t2_order", 32'(glog[k]), 32'd0);
`else
      chk("t2_order", 32'(glog[k]), 32'(k % N));
`endif
      if (k > 0) chk("t2_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
    end
    drain();

    // swap: old value returned, write only in the response cycle
    req(0, OP_SWAP, 40, 4'h8);
    #1;
    chk("t3_idle_we", 32'(bram_we), 32'd0);
    chk("t3_idle_en", 32'(bram_en), 32'd1);
    step();
    chk("t3_resp_we", 32'(bram_we), 32'd1);
    chk("t3_resp_addr", 32'(bram_addr), 32'd40);
    chk("t3_resp_din", 32'(bram_din), 32'h8);
    repeat (2) step();
    chk("t3_old", 32'(last_rd), 32'h2);
    req(0, OP_RD, 40, 4'h0);
    repeat (3) step();
    chk("t3_new", 32'(last_rd), 32'h8);
    drain();

    // swap and read of the same tile in one cycle
    do_reset();
    poke_en = 1'b1; poke_addr = 11'd40; poke_dat = 4'h2; mmem[40] = 4'h2;
    step();
    req(0, OP_SWAP, 40, 4'h8);
    req(1, OP_RD, 40, 4'h0);
    repeat (6) step();
    chk("t4_ngrant", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("t4_first", 32'(glog[0]), 32'd0);
      chk("t4_second", 32'(glog[1]), 32'd1);
    end
    chk("t4_data", 32'(last_rd), 32'h8);
    drain();

    // two held requesters
    do_reset();
    keep = 5'b00011;
    req(0, OP_RD, 60, 4'h0);
    req(1, OP_RD, 61, 4'h0);
    repeat (8) step();
    keep = '0;
    chk("t5_ngrant", 32'(glog.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < glog.size(); k++) begin
`ifdef MAP_ARB_PACMAN_PRIO_EN
      chk("t5_order", 32'(glog[k]), 32'd0);
`else
      chk("t5_order", 32'(glog[k]), 32'(k % 2));
`endif
    end
    drain();

    // reset during the response cycle of a swap
    do_reset();
    req(0, OP_SWAP, 50, 4'h8);
    step();
    chk("t6_resp_we", 32'(bram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(bram_we), 32'd0);
    chk("t6_rst_en", 32'(bram_en), 32'd0);
    chk("t6_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_rst_data", 32'(rsp_data), 32'd0);
    repeat (2) @(posedge vga_pix_clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    mmem[50] = 4'h1;
    req(1, OP_RD, 50, 4'h0);
    repeat (3) step();
    chk("t6_kept", 32'(last_rd), 32'h1);
    drain();

    // out-of-range address
    req(2, OP_RD, 1152, 4'h0);
    last_rd = 4'hf;
    #1;
    chk("t7_en", 32'(bram_en), 32'd0);
    chk("t7_ready", 32'(req_ready), 32'h4);
    repeat (3) step();
    chk("t7_data", 32'(last_rd), 32'h0);
    repeat (4) step();
    chk("t7_err", 32'(addr_err), 32'd1);
    drain();

    // randomized traffic on a small hot address window plus some out-of-range
    do_reset();
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          int a;
          a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1148, 1160))
                                          : int'($urandom_range(30, 45));
          req(i, 2'($urandom_range(0, 2)), a, 4'($urandom_range(0, 15)));
        end
      end
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
